mips_alu: RTL and testbench

Registered 32-bit MIPS-style arithmetic/logic unit for the datapath execute stage. It takes two operands and a 4-bit ALU control code from the ALU-control decoder. It produces the result, a Zero flag for branch resolution, and a signed-overflow flag. All outputs are registered with one-cycle latency.

---
 rtl/mips_alu_if.sv | 21 ++
 rtl/mips_alu.sv | 95 +++++++++
 tb/tb_mips_alu.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mips_alu_if.sv
// rtl/mips_alu_if.sv - Operand/result bundle between the execute-stage driver and mips_alu
interface mips_alu_if;
    logic [3:0]  ALUctl;
    logic [31:0] A;
    logic [31:0] B;
    logic        in_valid;
    logic [31:0] ALUOut;
    logic        Zero;
    logic        Overflow;
    logic        out_valid;

    modport master (
        output ALUctl, A, B, in_valid,
        input  ALUOut, Zero, Overflow, out_valid
    );

    modport slave (
        input  ALUctl, A, B, in_valid,
        output ALUOut, Zero, Overflow, out_valid
    );
endinterface

// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - Registered 32-bit MIPS ALU, one-cycle latency
// Optional shift ops (SLL/SRL/SRA) enabled by defining MIPSALU_SHIFT_EN.
module mips_alu (
    input  logic       clk,
    input  logic       reset,
    mips_alu_if.slave  alu
);
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd12;
`ifdef MIPSALU_SHIFT_EN
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SRA  = 4'd9;
`endif

    logic [31:0] sum;
    logic [31:0] diff;
    logic        ovf_add;
    logic        ovf_sub;
    logic        less_s;
    logic        less_u;
    logic [31:0] result;
    logic        result_ovf;

    logic [31:0] alu_out_d,   alu_out_q;
    logic        zero_d,      zero_q;
    logic        overflow_d,  overflow_q;
    logic        out_valid_d, out_valid_q;

    always_comb begin
        sum     = alu.A + alu.B;
        diff    = alu.A - alu.B;
        ovf_add = (alu.A[31] == alu.B[31]) && (sum[31]  != alu.A[31]);
        ovf_sub = (alu.A[31] != alu.B[31]) && (diff[31] != alu.A[31]);
        // Sign of the difference is wrong exactly when the subtract overflowed
        less_s  = diff[31] ^ ovf_sub;
        less_u  = alu.A < alu.B;

        result     = 32'd0;
        result_ovf = 1'b0;
        case (alu.ALUctl)
            OP_AND:  result = alu.A & alu.B;
            OP_OR:   result = alu.A | alu.B;
            OP_ADD:  begin result = sum;  result_ovf = ovf_add; end
            OP_XOR:  result = alu.A ^ alu.B;
            OP_SUB:  begin result = diff; result_ovf = ovf_sub; end
            OP_SLT:  result = {31'd0, less_s};
            OP_SLTU: result = {31'd0, less_u};
            OP_NOR:  result = ~(alu.A | alu.B);
`ifdef MIPSALU_SHIFT_EN
            OP_SLL:  result = alu.A << alu.B[4:0];
            OP_SRL:  result = alu.A >> alu.B[4:0];
            OP_SRA:  result = $unsigned($signed(alu.A) >>> alu.B[4:0]);
`endif
            default: result = 32'd0;
        endcase
    end

    always_comb begin
        alu_out_d   = alu_out_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        out_valid_d = alu.in_valid;
        if (alu.in_valid) begin
            alu_out_d  = result;
            zero_d     = (result == 32'd0);
            overflow_d = result_ovf;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_out_q   <= 32'd0;
            zero_q      <= 1'b1;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            alu_out_q   <= alu_out_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign alu.ALUOut    = alu_out_q;
    assign alu.Zero      = zero_q;
    assign alu.Overflow  = overflow_q;
    assign alu.out_valid = out_valid_q;
endmodule

// File: tb/tb_mips_alu.sv
// tb/tb_mips_alu.sv - Directed self-checking bench for mips_alu
module tb_mips_alu;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    mips_alu_if alu_if ();

    mips_alu dut (
        .clk   (clk),
        .reset (reset),
        .alu   (alu_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one op on the falling edge, check all outputs 1ns after the next rising edge
    task automatic run_op(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_out,
                          input logic exp_ovf);
        @(negedge clk);
        alu_if.ALUctl   = ctl;
        alu_if.A        = a;
        alu_if.B        = b;
        alu_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".out"},   alu_if.ALUOut, exp_out);
        check({tag, ".zero"},  {31'd0, alu_if.Zero}, {31'd0, exp_out == 32'd0});
        check({tag, ".ovf"},   {31'd0, alu_if.Overflow}, {31'd0, exp_ovf});
        check({tag, ".valid"}, {31'd0, alu_if.out_valid}, 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".out"},   alu_if.ALUOut, 32'd0);
        check({tag, ".zero"},  {31'd0, alu_if.Zero}, 32'd1);
        check({tag, ".ovf"},   {31'd0, alu_if.Overflow}, 32'd0);
        check({tag, ".valid"}, {31'd0, alu_if.out_valid}, 32'd0);
    endtask

    logic [31:0] exp_sll, exp_srl, exp_sra;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        alu_if.ALUctl   = 4'd0;
        alu_if.A        = 32'd0;
        alu_if.B        = 32'd0;
        alu_if.in_valid = 1'b0;

        // Asynchronous reset before any clock edge
        #3 reset = 1'b1;
        #1 check_reset_state("rst_async");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic ops, A=0xA B=0x5, back to back
        run_op("and",  4'd0, 32'hA, 32'h5, 32'h0, 1'b0);
        run_op("or",   4'd1, 32'hA, 32'h5, 32'hF, 1'b0);
        run_op("add",  4'd2, 32'hA, 32'h5, 32'hF, 1'b0);
        run_op("sub",  4'd6, 32'hA, 32'h5, 32'h5, 1'b0);
        run_op("slt",  4'd7, 32'hA, 32'h5, 32'h0, 1'b0);
        run_op("xor",  4'd3, 32'hA, 32'h6, 32'hC, 1'b0);

        // Overflow cases
        run_op("add_ovf", 4'd2, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1);
        run_op("sub_ovf", 4'd6, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1);
        run_op("sub_zero", 4'd6, 32'h5, 32'h5, 32'h0, 1'b0);
        run_op("add_neg_ovf", 4'd2, 32'h80000000, 32'h80000000, 32'h0, 1'b1);

        // Signed vs unsigned compare
        run_op("slt_neg",  4'd7, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0);
        run_op("sltu_big", 4'd8, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);
        run_op("nor",      4'd12, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);
        run_op("slt_min",  4'd7, 32'h80000000, 32'h1, 32'h1, 1'b0);
        run_op("slt_max",  4'd7, 32'h7FFFFFFF, 32'h80000000, 32'h0, 1'b0);
        run_op("sltu_lt",  4'd8, 32'h1, 32'hFFFFFFFF, 32'h1, 1'b0);

        // Shifts (zero when the shifter is not built)
`ifdef MIPSALU_SHIFT_EN
        exp_sll = 32'h00000100;
        exp_srl = 32'h08000001;
        exp_sra = 32'hF8000001;
`else
        exp_sll = 32'h0;
        exp_srl = 32'h0;
        exp_sra = 32'h0;
`endif
        run_op("sll", 4'd4, 32'h80000010, 32'd4, exp_sll, 1'b0);
        run_op("srl", 4'd5, 32'h80000010, 32'd4, exp_srl, 1'b0);
        run_op("sra", 4'd9, 32'h80000010, 32'd4, exp_sra, 1'b0);
`ifdef MIPSALU_SHIFT_EN
        run_op("sll0", 4'd4, 32'h12345678, 32'd0, 32'h12345678, 1'b0);
        run_op("sra31", 4'd9, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0);
`endif

        // Undefined code
        run_op("undef", 4'd15, 32'hA, 32'h5, 32'h0, 1'b0);

        // Hold when in_valid drops
        run_op("hold_add", 4'd2, 32'hA, 32'h5, 32'hF, 1'b0);
        @(negedge clk);
        alu_if.in_valid = 1'b0;
        alu_if.ALUctl   = 4'd0;
        alu_if.A        = 32'h0;
        @(posedge clk);
        #1;
        check("hold.out",   alu_if.ALUOut, 32'hF);
        check("hold.zero",  {31'd0, alu_if.Zero}, 32'd0);
        check("hold.valid", {31'd0, alu_if.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("hold2.out",  alu_if.ALUOut, 32'hF);

        // Reset between edges with an op in flight
        run_op("pre_rst", 4'd1, 32'hA, 32'h5, 32'hF, 1'b0);
        @(negedge clk);
        alu_if.ALUctl   = 4'd2;
        alu_if.A        = 32'h7FFFFFFF;
        alu_if.B        = 32'h1;
        alu_if.in_valid = 1'b1;
        #1 reset = 1'b1;
        #1 check_reset_state("rst_mid");
        @(posedge clk);
        #1 check_reset_state("rst_held");
        @(negedge clk);
        reset = 1'b0;
        run_op("post_rst", 4'd2, 32'h3, 32'h4, 32'h7, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
